datapath_core: RTL and testbench



---
 rtl/datapath_core_pkg.sv | 20 ++
 rtl/datapath_core_if.sv | 29 ++
 rtl/datapath_core_imm_gen.sv | 53 +++++
 rtl/datapath_core.sv | 45 ++++
 tb/tb_datapath_core.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/datapath_core_pkg.sv
// Shared widths, opcodes and immediate field positions for the register/operand stage.
// Build option: UPPER_IMM_EN adds the upper-immediate (UI) register in the immediate generator.
package datapath_core_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;

    localparam logic [2:0] OP_3R  = 3'b000;
    localparam logic [2:0] OP_2RI = 3'b001;
    localparam logic [2:0] OP_RI  = 3'b010;
    localparam logic [2:0] OP_L   = 3'b011;
    localparam logic [2:0] OP_UJ  = 3'b100;

    // Each immediate field runs from its LSB up to the instruction MSB.
    localparam int IMM_2RI_LSB = 9;
    localparam int IMM_RI_LSB  = 7;
    localparam int IMM_L_LSB   = 8;
    localparam int IMM_UJ_LSB  = 3;
    localparam int UI_W        = DATA_W - IMM_L_LSB;
endpackage

// File: rtl/datapath_core_if.sv
// Control/memory-side bus of the operand stage: register addresses, write-back sources,
// instruction word in; immediate and A/B operand latches out.
interface datapath_core_if;
    import datapath_core_pkg::*;

    logic [ADDR_W-1:0] input_reg_readA_address;
    logic [ADDR_W-1:0] input_reg_readB_address;
    logic              input_reg_write;
    logic [ADDR_W-1:0] input_reg_write_address;
    logic [DATA_W-1:0] input_imm;
    logic [DATA_W-1:0] input_ALUOut;
    logic [DATA_W-1:0] input_MDR;
    logic              memToReg;
    logic [DATA_W-1:0] output_imm;
    logic [DATA_W-1:0] output_reg_A;
    logic [DATA_W-1:0] output_reg_B;

    modport master (
        output input_reg_readA_address, input_reg_readB_address, input_reg_write,
               input_reg_write_address, input_imm, input_ALUOut, input_MDR, memToReg,
        input  output_imm, output_reg_A, output_reg_B
    );

    modport slave (
        input  input_reg_readA_address, input_reg_readB_address, input_reg_write,
               input_reg_write_address, input_imm, input_ALUOut, input_MDR, memToReg,
        output output_imm, output_reg_A, output_reg_B
    );
endinterface

// File: rtl/datapath_core_imm_gen.sv
// Immediate generator: combinational opcode-driven extension of the instruction word.
// Build option UPPER_IMM_EN: an L-type latches an 8-bit UI that replaces the upper byte of the next 2RI/RI.
module datapath_core_imm_gen
    import datapath_core_pkg::*;
(
`ifdef UPPER_IMM_EN
    input  logic              CLK,
    input  logic              RST,
`endif
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_imm
);
    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_ext;

    assign w_op = i_imm[2:0];

    always_comb begin
        w_ext = '0;
        case (w_op)
            OP_2RI:  w_ext = {{IMM_2RI_LSB{i_imm[DATA_W-1]}}, i_imm[DATA_W-1:IMM_2RI_LSB]};
            OP_RI:   w_ext = {{IMM_RI_LSB{i_imm[DATA_W-1]}},  i_imm[DATA_W-1:IMM_RI_LSB]};
            OP_L:    w_ext = {i_imm[DATA_W-1:IMM_L_LSB], {IMM_L_LSB{1'b0}}};
            OP_UJ:   w_ext = {{IMM_UJ_LSB{i_imm[DATA_W-1]}},  i_imm[DATA_W-1:IMM_UJ_LSB]};
            default: w_ext = '0;
        endcase
    end

`ifdef UPPER_IMM_EN
    logic            w_is_i;
    logic [UI_W-1:0] r_ui;
    logic            r_ui_vld;

    assign w_is_i = (w_op == OP_2RI) || (w_op == OP_RI);

    // The UI is consumed by exactly one 2RI/RI instruction, then the flag drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ui     <= '0;
            r_ui_vld <= 1'b0;
        end else if (w_op == OP_L) begin
            r_ui     <= i_imm[DATA_W-1:IMM_L_LSB];
            r_ui_vld <= 1'b1;
        end else if (w_is_i) begin
            r_ui_vld <= 1'b0;
        end
    end

    assign o_imm = (r_ui_vld && w_is_i) ? {r_ui, w_ext[DATA_W-UI_W-1:0]} : w_ext;
`else
    assign o_imm = w_ext;
`endif
endmodule

// File: rtl/datapath_core.sv
// Register file (8x16, r0 writable), write-back mux (MDR/ALUOut), A/B operand latches, immediate gen.
// A/B latency one cycle; same-edge write is seen by reads one cycle later. Build option: UPPER_IMM_EN.
module datapath_core
    import datapath_core_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    datapath_core_if.slave  bus
);
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] w_wb_dat;

    assign w_wb_dat = bus.memToReg ? bus.input_MDR : bus.input_ALUOut;

    // A/B sample the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (bus.input_reg_write) begin
                r_regs[bus.input_reg_write_address] <= w_wb_dat;
            end
            r_a <= r_regs[bus.input_reg_readA_address];
            r_b <= r_regs[bus.input_reg_readB_address];
        end
    end

    assign bus.output_reg_A = r_a;
    assign bus.output_reg_B = r_b;

    datapath_core_imm_gen u_imm_gen (
`ifdef UPPER_IMM_EN
        .CLK   (CLK),
        .RST   (RST),
`endif
        .i_imm (bus.input_imm),
        .o_imm (bus.output_imm)
    );
endmodule

// File: tb/tb_datapath_core.sv
// Bench for datapath_core: register-file/operand vectors and immediate vectors from tables,
// plus hand sequences for mid-run reset and the upper-immediate pairing.
module tb_datapath_core;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    datapath_core_if bus ();

    datapath_core dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [2:0]  waddr;
        logic        m2r;
        logic [15:0] mdr;
        logic [15:0] alu;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } rf_vec_t;

    typedef struct {
        logic [15:0] imm;
        logic [15:0] exp_imm;
    } imm_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } ab_t;

    rf_vec_t     rf_tab  [10];
    imm_vec_t    imm_tab [12];
    ab_t         sb_ab   [$];
    logic [15:0] sb_imm  [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_ab(input string name);
        ab_t e;
        if (sb_ab.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_ab.pop_front();
            check16({name, ".A"}, bus.output_reg_A, e.a);
            check16({name, ".B"}, bus.output_reg_B, e.b);
        end
    endtask

    task automatic pop_imm(input string name);
        logic [15:0] e;
        if (sb_imm.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_imm.pop_front();
            check16(name, bus.output_imm, e);
        end
    endtask

    task automatic drive_rf(input rf_vec_t v);
        bus.input_reg_write         = v.wr;
        bus.input_reg_write_address = v.waddr;
        bus.memToReg                = v.m2r;
        bus.input_MDR               = v.mdr;
        bus.input_ALUOut            = v.alu;
        bus.input_reg_readA_address = v.ra;
        bus.input_reg_readB_address = v.rb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //             wr  wa    m2r mdr       alu       ra    rb    expA      expB
        rf_tab[0] = '{1'b1, 3'd0, 1'b1, 16'h0001, 16'hDEAD, 3'd0, 3'd0, 16'h0000, 16'h0000};
        rf_tab[1] = '{1'b1, 3'd1, 1'b1, 16'h0005, 16'hDEAD, 3'd0, 3'd1, 16'h0001, 16'h0000};
        rf_tab[2] = '{1'b1, 3'd2, 1'b1, 16'h0010, 16'hDEAD, 3'd0, 3'd1, 16'h0001, 16'h0005};
        rf_tab[3] = '{1'b0, 3'd2, 1'b1, 16'hFFFF, 16'hFFFF, 3'd2, 3'd2, 16'h0010, 16'h0010};
        rf_tab[4] = '{1'b1, 3'd2, 1'b0, 16'hBEEF, 16'h1234, 3'd2, 3'd1, 16'h0010, 16'h0005};
        rf_tab[5] = '{1'b0, 3'd2, 1'b0, 16'h0000, 16'h0000, 3'd2, 3'd0, 16'h1234, 16'h0001};
        rf_tab[6] = '{1'b1, 3'd7, 1'b0, 16'h0000, 16'hA5A5, 3'd7, 3'd2, 16'h0000, 16'h1234};
        rf_tab[7] = '{1'b0, 3'd7, 1'b1, 16'hFFFF, 16'h0000, 3'd7, 3'd6, 16'hA5A5, 16'h0000};
        rf_tab[8] = '{1'b1, 3'd6, 1'b1, 16'h8001, 16'h7777, 3'd6, 3'd7, 16'h0000, 16'hA5A5};
        rf_tab[9] = '{1'b0, 3'd6, 1'b0, 16'h0000, 16'h0000, 3'd6, 3'd3, 16'h8001, 16'h0000};

        imm_tab[0]  = '{16'hFE01, 16'hFFFF};  // 2RI all ones
        imm_tab[1]  = '{16'h7E01, 16'h003F};  // 2RI positive
        imm_tab[2]  = '{16'h00B2, 16'h0001};  // RI 1
        imm_tab[3]  = '{16'h8002, 16'hFF00};  // RI negative
        imm_tab[4]  = '{16'h006C, 16'h000D};  // UJ 13
        imm_tab[5]  = '{16'h8004, 16'hF000};  // UJ negative
        imm_tab[6]  = '{16'hFFF8, 16'h0000};  // 3R
        imm_tab[7]  = '{16'hFFFD, 16'h0000};  // op 101
        imm_tab[8]  = '{16'hFFFE, 16'h0000};  // op 110
        imm_tab[9]  = '{16'hFFFF, 16'h0000};  // op 111
        imm_tab[10] = '{16'h0003, 16'h0000};  // L zeros
        imm_tab[11] = '{16'hAB03, 16'hAB00};  // L upper byte

        bus.input_reg_write         = 1'b0;
        bus.input_reg_write_address = '0;
        bus.input_reg_readA_address = '0;
        bus.input_reg_readB_address = '0;
        bus.memToReg                = 1'b0;
        bus.input_MDR               = '0;
        bus.input_ALUOut            = '0;
        bus.input_imm               = '0;

        #2 RST = 1'b1;
        #1;
        check16("reset.A", bus.output_reg_A, 16'h0000);
        check16("reset.B", bus.output_reg_B, 16'h0000);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            drive_rf(rf_tab[i]);
            sb_ab.push_back('{rf_tab[i].exp_a, rf_tab[i].exp_b});
            @(posedge CLK);
            #1;
            pop_ab($sformatf("rf[%0d]", i));
        end

        // Mid-run reset must clear the latches without waiting for a clock edge.
        @(negedge CLK);
        bus.input_reg_write = 1'b0;
        #1 RST = 1'b1;
        #1;
        check16("midrst.A", bus.output_reg_A, 16'h0000);
        check16("midrst.B", bus.output_reg_B, 16'h0000);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            bus.input_reg_readA_address = 3'(i);
            bus.input_reg_readB_address = 3'(7 - i);
            sb_ab.push_back('{16'h0000, 16'h0000});
            @(posedge CLK);
            #1;
            pop_ab($sformatf("postrst[%0d]", i));
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            bus.input_imm = imm_tab[i].imm;
            sb_imm.push_back(imm_tab[i].exp_imm);
            #1;
            pop_imm($sformatf("imm[%0d]", i));
        end

        // L followed by two RI instructions: only the first RI may pick up the UI byte.
        @(negedge CLK);
        bus.input_imm = 16'hAB03;
        sb_imm.push_back(16'hAB00);
        #1 pop_imm("ui.L");
        @(negedge CLK);
        bus.input_imm = 16'h0082;
`ifdef UPPER_IMM_EN
        sb_imm.push_back(16'hAB01);
`else
        sb_imm.push_back(16'h0001);
`endif
        #1 pop_imm("ui.RI1");
        @(negedge CLK);
        bus.input_imm = 16'h0082;
        sb_imm.push_back(16'h0001);
        #1 pop_imm("ui.RI2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
